// File: rtl/repetition_time_controller_if.sv
// Handshake bundle for the repetition time controller: word write port,
// outbound and inbound channel beats, and the voted read port with status.
interface repetition_time_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_valid;
  logic                  write_ready;
  logic [DATA_WIDTH-1:0] channel_out_data;
  logic                  channel_out_valid;
  logic                  channel_out_ready;
  logic                  channel_out_last;
  logic [DATA_WIDTH-1:0] channel_in_data;
  logic                  channel_in_valid;
  logic                  channel_in_last;
  logic                  channel_in_ready;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  read_ready;
  logic                  read_error;
  logic                  read_uncorrectable;
  logic                  read_desync;

  modport master (
    input  write_data, write_valid,
    output write_ready,
    output channel_out_data, channel_out_valid, channel_out_last,
    input  channel_out_ready,
    input  channel_in_data, channel_in_valid, channel_in_last,
    output channel_in_ready,
    output read_data, read_valid, read_error, read_uncorrectable, read_desync,
    input  read_ready
  );

  modport slave (
    output write_data, write_valid,
    input  write_ready,
    input  channel_out_data, channel_out_valid, channel_out_last,
    output channel_out_ready,
    output channel_in_data, channel_in_valid, channel_in_last,
    input  channel_in_ready,
    input  read_data, read_valid, read_error, read_uncorrectable, read_desync,
    output read_ready
  );
endinterface

// File: rtl/repetition_time_controller.sv
// Time-domain repetition code: TX repeats each word REPETITION times on the
// channel; RX accumulates per-bit one counts over the copies and votes.
module repetition_time_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int REPETITION = 3
) (
  input logic clock,
  input logic reset,
  repetition_time_controller_if.master bus
);

  localparam int COUNT_WIDTH = $clog2(REPETITION + 1);
  localparam int CMP_W       = COUNT_WIDTH + 1;
  localparam logic [CMP_W-1:0]       REP_CMP  = CMP_W'(REPETITION);
  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(REPETITION - 1);

  // Doubling the count avoids a divide; one extra bit keeps 2*R from wrapping.
  function automatic logic vote_bit(input logic [COUNT_WIDTH-1:0] n);
    return {n, 1'b0} > REP_CMP;
  endfunction

  function automatic logic vote_tie(input logic [COUNT_WIDTH-1:0] n);
    return {n, 1'b0} == REP_CMP;
  endfunction

  function automatic logic vote_dissent(input logic [COUNT_WIDTH-1:0] n,
                                        input logic [COUNT_WIDTH-1:0] copies);
    return (n != '0) && (n != copies);
  endfunction

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

  tx_state_t               tx_state, tx_state_next;
  logic [DATA_WIDTH-1:0]   tx_data, tx_data_next;
  logic [COUNT_WIDTH-1:0]  tx_count, tx_count_next;
  logic                    tx_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_data  <= '0;
      tx_count <= '0;
    end else begin
      tx_state <= tx_state_next;
      tx_data  <= tx_data_next;
      tx_count <= tx_count_next;
    end
  end

  always_comb begin
    tx_state_next         = tx_state;
    tx_data_next          = tx_data;
    tx_count_next         = tx_count;
    tx_last               = (tx_count == LAST_IDX);
    bus.write_ready       = 1'b0;
    bus.channel_out_valid = 1'b0;
    bus.channel_out_last  = 1'b0;
    bus.channel_out_data  = tx_data;
    case (tx_state)
      TX_IDLE: begin
        bus.write_ready = 1'b1;
        if (bus.write_valid) begin
          tx_data_next  = bus.write_data;
          tx_count_next = '0;
          tx_state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        bus.channel_out_valid = 1'b1;
        bus.channel_out_last  = tx_last;
        // Accepting on the final-copy handshake keeps the link busy every cycle.
        bus.write_ready       = tx_last && bus.channel_out_ready;
        if (bus.channel_out_ready) begin
          if (!tx_last) begin
            tx_count_next = tx_count + COUNT_WIDTH'(1);
          end else if (bus.write_valid) begin
            tx_data_next  = bus.write_data;
            tx_count_next = '0;
          end else begin
            tx_count_next = '0;
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  rx_state_t               rx_state, rx_state_next;
  logic [COUNT_WIDTH-1:0]  ones     [DATA_WIDTH];
  logic [COUNT_WIDTH-1:0]  ones_sum [DATA_WIDTH];
  logic [COUNT_WIDTH-1:0]  rx_count, copies;
  logic                    rx_take, rx_final;
  logic [DATA_WIDTH-1:0]   vote_data, read_data_r;
  logic                    vote_error, vote_uncorr, vote_desync;
  logic                    read_error_r, read_uncorr_r, read_desync_r;

  always_comb begin
    rx_take     = (rx_state == RX_COLLECT) && bus.channel_in_valid;
    rx_final    = bus.channel_in_last || (rx_count == LAST_IDX);
    copies      = rx_count + COUNT_WIDTH'(1);
    vote_desync = bus.channel_in_last != (rx_count == LAST_IDX);
    vote_error  = vote_desync;
    vote_uncorr = 1'b0;
    vote_data   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ones_sum[i]  = ones[i] + COUNT_WIDTH'(bus.channel_in_data[i]);
      vote_data[i] = vote_bit(ones_sum[i]);
      if (vote_dissent(ones_sum[i], copies)) vote_error  = 1'b1;
      if (vote_tie(ones_sum[i]))             vote_uncorr = 1'b1;
    end
    rx_state_next        = rx_state;
    bus.channel_in_ready = (rx_state == RX_COLLECT);
    bus.read_valid       = (rx_state == RX_HOLD);
    case (rx_state)
      RX_COLLECT: if (rx_take && rx_final) rx_state_next = RX_HOLD;
      RX_HOLD:    if (bus.read_ready)      rx_state_next = RX_COLLECT;
      default:    rx_state_next = RX_COLLECT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state      <= RX_COLLECT;
      rx_count      <= '0;
      ones          <= '{default: '0};
      read_data_r   <= '0;
      read_error_r  <= 1'b0;
      read_uncorr_r <= 1'b0;
      read_desync_r <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      if (rx_take) begin
        for (int i = 0; i < DATA_WIDTH; i++)
          ones[i] <= rx_final ? '0 : ones_sum[i];
        if (rx_final) begin
          rx_count      <= '0;
          read_data_r   <= vote_data;
          read_error_r  <= vote_error;
          read_uncorr_r <= vote_uncorr;
          read_desync_r <= vote_desync;
        end else begin
          rx_count <= rx_count + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.read_data          = read_data_r;
  assign bus.read_error         = read_error_r;
  assign bus.read_uncorrectable = read_uncorr_r;
  assign bus.read_desync        = read_desync_r;

endmodule

// File: tb/tb_repetition_time_controller.sv
// Bench for repetition_time_controller: R=3 and R=4 instances, directed
// vectors plus randomized traffic against a queue/counting reference model.
module tb_repetition_time_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  repetition_time_controller_if #(.DATA_WIDTH(8)) if3();
  repetition_time_controller_if #(.DATA_WIDTH(8)) if4();

  repetition_time_controller #(.DATA_WIDTH(8), .REPETITION(3)) u3 (
    .clock(clock), .reset(reset), .bus(if3.master));
  repetition_time_controller #(.DATA_WIDTH(8), .REPETITION(4)) u4 (
    .clock(clock), .reset(reset), .bus(if4.master));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic err, unc, des, valid, in_ready;
  } rx_obs_t;

  typedef struct packed { logic [7:0] d; logic l; } beat_t;

  localparam logic [23:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'b000};

  logic       tx_v [16];
  logic [7:0] tx_d [16];
  logic       tx_l [16];
  logic       tx_wr[16];
  logic [7:0] rx_cp[4];

  function automatic logic [23:0] pack_out(input int sel);
    if (sel == 3)
      return {if3.write_ready, if3.channel_out_valid, if3.channel_out_last, if3.channel_out_data,
              if3.channel_in_ready, if3.read_valid, if3.read_data,
              if3.read_error, if3.read_uncorrectable, if3.read_desync};
    return {if4.write_ready, if4.channel_out_valid, if4.channel_out_last, if4.channel_out_data,
            if4.channel_in_ready, if4.read_valid, if4.read_data,
            if4.read_error, if4.read_uncorrectable, if4.read_desync};
  endfunction

  function automatic rx_obs_t get_rx(input int sel);
    rx_obs_t o;
    if (sel == 3)
      o = '{data: if3.read_data, err: if3.read_error, unc: if3.read_uncorrectable,
            des: if3.read_desync, valid: if3.read_valid, in_ready: if3.channel_in_ready};
    else
      o = '{data: if4.read_data, err: if4.read_error, unc: if4.read_uncorrectable,
            des: if4.read_desync, valid: if4.read_valid, in_ready: if4.channel_in_ready};
    return o;
  endfunction

  // Majority vote over the copies in rx_cp, computed by counting ones per bit.
  function automatic rx_obs_t ref_vote(input int n, input int rep, input bit lastf);
    rx_obs_t r;
    int ones;
    r = '{default: 1'b0};
    r.valid = 1'b1;
    r.des   = !(n == rep && lastf);
    r.err   = r.des;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(rx_cp[k][b]);
      r.data[b] = (2 * ones > rep);
      if (ones != 0 && ones != n) r.err = 1'b1;
      if (2 * ones == rep)        r.unc = 1'b1;
    end
    return r;
  endfunction

  task automatic set_rx(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 3) begin if3.channel_in_valid = v; if3.channel_in_data = d; if3.channel_in_last = l; end
    else          begin if4.channel_in_valid = v; if4.channel_in_data = d; if4.channel_in_last = l; end
  endtask

  task automatic set_rr(input int sel, input logic r);
    if (sel == 3) if3.read_ready = r;
    else          if4.read_ready = r;
  endtask

  task automatic tx_word(input logic [7:0] w, input logic [15:0] pat, input int ncyc);
    @(negedge clock);
    if3.write_data  = w;
    if3.write_valid = 1'b1;
    @(negedge clock);
    if3.write_valid = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if3.channel_out_ready = pat[k];
      #1;
      tx_v[k]  = if3.channel_out_valid;
      tx_d[k]  = if3.channel_out_data;
      tx_l[k]  = if3.channel_out_last;
      tx_wr[k] = if3.write_ready;
      @(negedge clock);
    end
  endtask

  task automatic rx_word(input int sel, input int n, input bit lastf, input int hold,
                         output rx_obs_t o, output bit timeout);
    rx_obs_t cur;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      set_rx(sel, 1'b1, rx_cp[k], (k == n - 1) ? lastf : 1'b0);
    end
    @(negedge clock);
    set_rx(sel, 1'b0, 8'h00, 1'b0);
    timeout = 1'b1;
    o = get_rx(sel);
    for (int t = 0; t < 6; t++) begin
      cur = get_rx(sel);
      if (cur.valid) begin timeout = 1'b0; o = cur; break; end
      @(negedge clock);
    end
    repeat (hold) @(negedge clock);
    set_rr(sel, 1'b1);
    @(negedge clock);
    set_rr(sel, 1'b0);
  endtask

  task automatic test_reset;
    @(negedge clock);
    for (int s = 3; s <= 4; s++) begin
      checks++;
      if (pack_out(s) !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_state R=%0d: got %h expected %h", s, pack_out(s), RESET_VEC);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_tx_basic;
    logic ev, el, ewr;
    tx_word(8'hA5, 16'hFFFF, 4);
    for (int k = 0; k < 4; k++) begin
      ev = (k < 3); el = (k == 2); ewr = (k >= 2);
      checks++;
      if ({tx_v[k], tx_l[k], tx_wr[k]} !== {ev, el, ewr} || (ev && tx_d[k] !== 8'hA5)) begin
        errors++;
        $display("FAIL tx_basic cycle %0d: got v/l/wr=%b%b%b data=%h expected %b%b%b data=a5",
                 k, tx_v[k], tx_l[k], tx_wr[k], tx_d[k], ev, el, ewr);
      end
    end
  endtask

  task automatic test_tx_stall;
    logic [15:0] pat;
    logic [7:0]  w;
    int idx, xfer;
    logic ev, el, ewr;
    for (int p = 0; p < 5; p++) begin
      pat = (p == 0) ? 16'hFFF5 : (16'($urandom) | 16'hFF00);
      w   = 8'($urandom);
      tx_word(w, pat, 16);
      idx = 0; xfer = 0;
      for (int k = 0; k < 16; k++) begin
        ev = (idx < 3); el = (idx == 2); ewr = !ev || (el && pat[k]);
        checks++;
        if ({tx_v[k], tx_l[k], tx_wr[k]} !== {ev, el, ewr} || (ev && tx_d[k] !== w)) begin
          errors++;
          $display("FAIL tx_stall pat %h cycle %0d: got v/l/wr=%b%b%b data=%h expected %b%b%b data=%h",
                   pat, k, tx_v[k], tx_l[k], tx_wr[k], tx_d[k], ev, el, ewr, w);
        end
        if (ev && pat[k]) idx++;
        if (tx_v[k] === 1'b1 && pat[k]) xfer++;
      end
      checks++;
      if (xfer != 3) begin
        errors++;
        $display("FAIL tx_stall_transfers pat %h: got %0d expected 3", pat, xfer);
      end
    end
  endtask

  task automatic test_back_to_back;
    beat_t q[$];
    bit accepted = 1'b0;
    logic ewr;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      checks++;
      if (if3.channel_out_valid !== (q.size() != 0) ||
          (q.size() != 0 && {if3.channel_out_data, if3.channel_out_last} !== {q[0].d, q[0].l})) begin
        errors++;
        $display("FAIL back_to_back beat cycle %0d: got v=%b data=%h last=%b expected v=%b head=%h",
                 cyc, if3.channel_out_valid, if3.channel_out_data, if3.channel_out_last,
                 q.size() != 0, (q.size() != 0) ? q[0] : 9'h0);
      end
      if (!if3.write_valid || accepted) begin
        if3.write_valid = (cyc < 360) && ($urandom_range(0, 3) != 0);
        if3.write_data  = 8'($urandom);
      end
      if3.channel_out_ready = (cyc >= 360) || ($urandom_range(0, 3) != 0);
      #1;
      ewr = (q.size() == 0) || (q.size() == 1 && if3.channel_out_ready);
      checks++;
      if (if3.write_ready !== ewr) begin
        errors++;
        $display("FAIL back_to_back write_ready cycle %0d: got %b expected %b", cyc, if3.write_ready, ewr);
      end
      accepted = if3.write_valid && if3.write_ready;
      if (if3.channel_out_valid && if3.channel_out_ready && q.size() != 0) void'(q.pop_front());
      if (accepted)
        for (int k = 0; k < 3; k++) q.push_back('{d: if3.write_data, l: (k == 2)});
    end
    @(negedge clock);
    if3.write_valid = 1'b0;
    checks++;
    if (q.size() != 0 || if3.channel_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: got pending=%0d valid=%b expected 0 0", q.size(), if3.channel_out_valid);
    end
  endtask

  task automatic test_rx_vectors;
    rx_obs_t o, e;
    bit to;
    rx_cp[0] = 8'hA5; rx_cp[1] = 8'hA5; rx_cp[2] = 8'h25;
    rx_word(3, 3, 1'b1, 2, o, to);
    e = '{data: 8'hA5, err: 1'b1, unc: 1'b0, des: 1'b0, valid: 1'b1, in_ready: 1'b0};
    checks++;
    if (to || o !== e) begin errors++; $display("FAIL rx_single_flip: got %h timeout=%b expected %h", o, to, e); end

    rx_cp[0] = 8'hFF; rx_cp[1] = 8'hFF; rx_cp[2] = 8'h00; rx_cp[3] = 8'h00;
    rx_word(4, 4, 1'b1, 1, o, to);
    e = '{data: 8'h00, err: 1'b1, unc: 1'b1, des: 1'b0, valid: 1'b1, in_ready: 1'b0};
    checks++;
    if (to || o !== e) begin errors++; $display("FAIL rx_tie_r4: got %h timeout=%b expected %h", o, to, e); end

    rx_cp[0] = 8'h0F; rx_cp[1] = 8'h0F;
    rx_word(3, 2, 1'b1, 0, o, to);
    e = '{data: 8'h0F, err: 1'b1, unc: 1'b0, des: 1'b1, valid: 1'b1, in_ready: 1'b0};
    checks++;
    if (to || o !== e) begin errors++; $display("FAIL rx_early_last: got %h timeout=%b expected %h", o, to, e); end

    rx_cp[0] = 8'h3C; rx_cp[1] = 8'h3C; rx_cp[2] = 8'h3C;
    rx_word(3, 3, 1'b1, 0, o, to);
    e = '{data: 8'h3C, err: 1'b0, unc: 1'b0, des: 1'b0, valid: 1'b1, in_ready: 1'b0};
    checks++;
    if (to || o !== e) begin errors++; $display("FAIL rx_after_desync: got %h timeout=%b expected %h", o, to, e); end
  endtask

  task automatic test_rx_random;
    rx_obs_t o, e;
    bit to, lastf;
    int sel, rep, n;
    logic [7:0] base;
    for (int w = 0; w < 40; w++) begin
      sel   = (w % 2 == 0) ? 3 : 4;
      rep   = sel;
      n     = $urandom_range(1, rep);
      lastf = (n < rep) ? 1'b1 : ($urandom_range(0, 3) != 0);
      base  = 8'($urandom);
      for (int k = 0; k < 4; k++)
        rx_cp[k] = base ^ (($urandom_range(0, 1) != 0) ? 8'($urandom & $urandom) : 8'h00);
      rx_word(sel, n, lastf, $urandom_range(0, 2), o, to);
      e = ref_vote(n, rep, lastf);
      checks++;
      if (to || o !== e) begin
        errors++;
        $display("FAIL rx_random word %0d R=%0d n=%0d last=%b: got %h timeout=%b expected %h",
                 w, rep, n, lastf, o, to, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    rx_obs_t o, e;
    bit to;
    @(negedge clock);
    if3.write_data = 8'hC3; if3.write_valid = 1'b1; if3.channel_out_ready = 1'b0;
    @(negedge clock);
    if3.write_valid = 1'b0;
    set_rx(3, 1'b1, 8'hFF, 1'b0);
    @(negedge clock);
    set_rx(3, 1'b0, 8'h00, 1'b0);
    checks++;
    if (if3.channel_out_valid !== 1'b1 || if3.channel_out_data !== 8'hC3) begin
      errors++;
      $display("FAIL mid_send_setup: got v=%b data=%h expected 1 c3", if3.channel_out_valid, if3.channel_out_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pack_out(3) !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", pack_out(3), RESET_VEC);
    end
    @(negedge clock);
    reset = 1'b0;
    rx_cp[0] = 8'h5A; rx_cp[1] = 8'h5A; rx_cp[2] = 8'h5A;
    rx_word(3, 3, 1'b1, 0, o, to);
    e = '{data: 8'h5A, err: 1'b0, unc: 1'b0, des: 1'b0, valid: 1'b1, in_ready: 1'b0};
    checks++;
    if (to || o !== e) begin errors++; $display("FAIL rx_after_reset: got %h timeout=%b expected %h", o, to, e); end
    tx_word(8'h3C, 16'hFFFF, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_v[k] !== (k < 3) || tx_l[k] !== (k == 2) || (k < 3 && tx_d[k] !== 8'h3C)) begin
        errors++;
        $display("FAIL tx_after_reset cycle %0d: got v=%b l=%b data=%h expected v=%b l=%b data=3c",
                 k, tx_v[k], tx_l[k], tx_d[k], k < 3, k == 2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    if3.write_data = '0; if3.write_valid = 1'b0; if3.channel_out_ready = 1'b0;
    if3.channel_in_data = '0; if3.channel_in_valid = 1'b0; if3.channel_in_last = 1'b0;
    if3.read_ready = 1'b0;
    if4.write_data = '0; if4.write_valid = 1'b0; if4.channel_out_ready = 1'b0;
    if4.channel_in_data = '0; if4.channel_in_valid = 1'b0; if4.channel_in_last = 1'b0;
    if4.read_ready = 1'b0;
    repeat (2) @(posedge clock);
    test_reset;
    test_tx_basic;
    test_tx_stall;
    test_back_to_back;
    test_rx_vectors;
    test_rx_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
